// File: rtl/wb_ahb3lite_master_bridge.sv
// -----------------------------------------------------------------------------
// wb_ahb3lite_master_bridge
// Wishbone-classic slave to AHB3-Lite master bridge. Every Wishbone beat
// becomes one SINGLE/NONSEQ AHB transfer; there is never more than one
// transfer outstanding.
//
// Parameters:
//   HPROT_VAL       constant driven on mHPROT
// Ports:
//   clk_i, rst_n_i  clock (rising edge), async active-low reset
//   wb_*            Wishbone-classic slave side (adr/dat/sel/we/cyc/stb in,
//                   dat/ack/err out; ack/err are one-cycle pulses)
//   mH*             AHB3-Lite master side; mHREADY is a combinational copy
//                   of mHREADYOUT
// Build option:
//   WB_AHB_SIZE_DECODE_EN  decode wb_sel_i into HSIZE and HADDR[1:0];
//                          unsupported lane patterns return wb_err_o
//                          without an AHB transfer. Undefined: word only.
// -----------------------------------------------------------------------------
module wb_ahb3lite_master_bridge #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        mHSEL,
   output logic [31:0] mHADDR,
   output logic [31:0] mHWDATA,
   output logic        mHWRITE,
   output logic [2:0]  mHSIZE,
   output logic [2:0]  mHBURST,
   output logic [3:0]  mHPROT,
   output logic [1:0]  mHTRANS,
   input  logic [31:0] mHRDATA,
   input  logic        mHREADYOUT,
   input  logic        mHRESP,
   output logic        mHREADY
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] haddr_nxt;
   logic [DW-1:0] hwdata_nxt;
   logic [DW-1:0] wb_dat_nxt;
   logic [2:0]    hsize_nxt;
   logic [1:0]    htrans_nxt;
   logic          hsel_nxt;
   logic          hwrite_nxt;
   logic          ack_nxt;
   logic          err_nxt;
   logic          abort_q, abort_nxt;
   logic          req_c;
   logic [2:0]    size_dec;
   logic [1:0]    lane_dec;
   logic          sel_ok;

   // Fixed AHB qualifiers and ready pass-through
   assign mHBURST = 3'b000;
   assign mHPROT  = HPROT_VAL;
   assign mHREADY = mHREADYOUT;

   // Low address bits always come from the lane decode, never from the bus
   logic unused_adr_lsb;
   assign unused_adr_lsb = ^wb_adr_i[1:0];

`ifdef WB_AHB_SIZE_DECODE_EN
   // Byte-lane pattern to transfer size and byte offset
   always_comb begin
      size_dec = HSIZE_WORD;
      lane_dec = 2'b00;
      sel_ok   = 1'b1;
      case (wb_sel_i)
         4'b1111: begin size_dec = HSIZE_WORD; lane_dec = 2'b00; end
         4'b0011: begin size_dec = HSIZE_HALF; lane_dec = 2'b00; end
         4'b1100: begin size_dec = HSIZE_HALF; lane_dec = 2'b10; end
         4'b0001: begin size_dec = HSIZE_BYTE; lane_dec = 2'b00; end
         4'b0010: begin size_dec = HSIZE_BYTE; lane_dec = 2'b01; end
         4'b0100: begin size_dec = HSIZE_BYTE; lane_dec = 2'b10; end
         4'b1000: begin size_dec = HSIZE_BYTE; lane_dec = 2'b11; end
         default: sel_ok = 1'b0;
      endcase
   end
`else
   // Word-only build: byte lanes are not looked at
   logic unused_sel;
   assign unused_sel = ^wb_sel_i;
   assign size_dec   = HSIZE_WORD;
   assign lane_dec   = 2'b00;
   assign sel_ok     = 1'b1;
`endif

   // New beat; the pulse terms stop a held strobe from reissuing a beat
   assign req_c = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

   // Next-state and next-output logic
   always_comb begin
      state_nxt  = state;
      haddr_nxt  = mHADDR;
      hwdata_nxt = mHWDATA;
      hwrite_nxt = mHWRITE;
      hsize_nxt  = mHSIZE;
      htrans_nxt = mHTRANS;
      hsel_nxt   = mHSEL;
      wb_dat_nxt = wb_dat_o;
      ack_nxt    = 1'b0;
      err_nxt    = 1'b0;
      abort_nxt  = abort_q;

      case (state)
         ST_IDLE: begin
            abort_nxt = 1'b0;
            if (req_c) begin
               if (!sel_ok) begin
                  err_nxt = 1'b1;
               end else begin
                  haddr_nxt  = {wb_adr_i[AW-1:2], lane_dec};
                  hwrite_nxt = wb_we_i;
                  hsize_nxt  = size_dec;
                  hwdata_nxt = wb_dat_i;
                  htrans_nxt = HTRANS_NONSEQ;
                  hsel_nxt   = 1'b1;
                  state_nxt  = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (!wb_cyc_i) abort_nxt = 1'b1;
            if (mHREADYOUT) begin
               htrans_nxt = HTRANS_IDLE;
               hsel_nxt   = 1'b0;
               state_nxt  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (!wb_cyc_i) abort_nxt = 1'b1;
            // Abandoned cycles still finish on AHB but report nothing back
            if (mHREADYOUT) begin
               state_nxt = ST_IDLE;
               if (wb_cyc_i && !abort_q) begin
                  if (mHRESP) begin
                     err_nxt = 1'b1;
                  end else begin
                     ack_nxt = 1'b1;
                     if (!mHWRITE) wb_dat_nxt = mHRDATA;
                  end
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= ST_IDLE;
         mHADDR   <= '0;
         mHWDATA  <= '0;
         mHWRITE  <= 1'b0;
         mHSIZE   <= HSIZE_WORD;
         mHTRANS  <= HTRANS_IDLE;
         mHSEL    <= 1'b0;
         wb_dat_o <= '0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         mHADDR   <= haddr_nxt;
         mHWDATA  <= hwdata_nxt;
         mHWRITE  <= hwrite_nxt;
         mHSIZE   <= hsize_nxt;
         mHTRANS  <= htrans_nxt;
         mHSEL    <= hsel_nxt;
         wb_dat_o <= wb_dat_nxt;
         wb_ack_o <= ack_nxt;
         wb_err_o <= err_nxt;
         abort_q  <= abort_nxt;
      end
   end

endmodule

// File: tb/tb_wb_ahb3lite_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_ahb3lite_master_bridge
// Scoreboard bench: each Wishbone beat pushes its expected response (kind,
// latency, read data); a monitor pops and compares on every ack/err pulse.
// A behavioural AHB slave with programmable address/data waits and a
// two-cycle ERROR response sits on the master port.
// -----------------------------------------------------------------------------
module tb_wb_ahb3lite_master_bridge;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
   logic        mHSEL, mHWRITE, mHREADYOUT, mHRESP, mHREADY;
   logic [31:0] mHADDR, mHWDATA, mHRDATA;
   logic [2:0]  mHSIZE, mHBURST;
   logic [3:0]  mHPROT;
   logic [1:0]  mHTRANS;

   wb_ahb3lite_master_bridge dut (
      .clk_i(clk), .rst_n_i(rst_n_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
      .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .mHSEL(mHSEL), .mHADDR(mHADDR), .mHWDATA(mHWDATA), .mHWRITE(mHWRITE),
      .mHSIZE(mHSIZE), .mHBURST(mHBURST), .mHPROT(mHPROT), .mHTRANS(mHTRANS),
      .mHRDATA(mHRDATA), .mHREADYOUT(mHREADYOUT), .mHRESP(mHRESP),
      .mHREADY(mHREADY)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          err;
      bit          chk_data;
      logic [31:0] data;
      int          start;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int n_checks  = 0;
   int n_errors  = 0;
   int cycnt     = 0;
   int pulse_cnt = 0;
   int n_xfer    = 0;
   int exp_xfer  = 0;

   // Slave configuration and capture
   int          cfg_aw = 0, cfg_dw = 0;
   bit          cfg_err = 1'b0;
   logic [31:0] cfg_rdata = '0;
   logic [31:0] cap_wdata = '0;
   logic        slv_we = 1'b0;
   int          ss = 0, ac = 0, dc = 0;

   always @(posedge clk) cycnt <= cycnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, want, cycnt);
      end
   endtask

   // Behavioural AHB slave: decides HREADYOUT/HRESP for the next edge
   initial begin
      mHREADYOUT = 1'b1;
      mHRESP     = 1'b0;
      mHRDATA    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n_i) begin
            ss = 0; ac = 0; dc = 0;
            mHREADYOUT = 1'b1;
            mHRESP     = 1'b0;
         end else begin
            case (ss)
               1: begin
                  if (dc < cfg_dw) begin
                     mHREADYOUT = 1'b0; mHRESP = 1'b0; dc++;
                  end else if (cfg_err) begin
                     mHREADYOUT = 1'b0; mHRESP = 1'b1; ss = 2;
                  end else begin
                     mHREADYOUT = 1'b1; mHRESP = 1'b0;
                     mHRDATA    = cfg_rdata;
                     if (slv_we) cap_wdata = mHWDATA;
                     ss = 0;
                  end
               end
               2: begin
                  mHREADYOUT = 1'b1; mHRESP = 1'b1; ss = 0;
               end
               default: begin
                  mHRESP = 1'b0;
                  if (mHSEL && mHTRANS == 2'b10) begin
                     if (ac < cfg_aw) begin
                        mHREADYOUT = 1'b0; ac++;
                     end else begin
                        mHREADYOUT = 1'b1; ac = 0; dc = 0;
                        slv_we = mHWRITE;
                        n_xfer++;
                        ss = 1;
                     end
                  end else begin
                     mHREADYOUT = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // Response monitor: pops the scoreboard on every ack/err pulse
   always @(negedge clk) begin
      if (rst_n_i && (wb_ack_o || wb_err_o)) begin
         pulse_cnt = pulse_cnt + 1;
         if (exp_q.size() == 0) begin
            check("spurious_resp", 32'({wb_ack_o, wb_err_o}), 32'h0);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_kind", 32'({wb_ack_o, wb_err_o}), mon_e.err ? 32'h1 : 32'h2);
            check("resp_latency", 32'(cycnt - mon_e.start), 32'(mon_e.lat));
            if (mon_e.chk_data) check("resp_rdata", wb_dat_o, mon_e.data);
         end
      end
   end

   // One Wishbone beat with address/data phase probes
   task automatic beat(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                       input logic [3:0] sel, input int aw, input int dw, input bit err_resp,
                       input logic [31:0] rdata, input logic [31:0] exp_haddr,
                       input logic [2:0] exp_hsize, input bit xfer);
      exp_t x;
      int   n;
      cfg_aw = aw; cfg_dw = dw; cfg_err = err_resp; cfg_rdata = rdata;
      @(negedge clk);
      wb_adr_i = adr; wb_dat_i = dat; wb_we_i = we; wb_sel_i = sel;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      x.err      = err_resp || !xfer;
      x.chk_data = !x.err && !we;
      x.data     = rdata;
      x.start    = cycnt;
      x.lat      = xfer ? (3 + aw + dw + (err_resp ? 1 : 0)) : 1;
      exp_q.push_back(x);
      if (xfer) begin
         exp_xfer++;
         for (int k = 1; k <= aw + 1; k++) begin
            @(negedge clk);
            check("addr_htrans", 32'(mHTRANS), 32'h2);
            check("addr_haddr", mHADDR, exp_haddr);
            if (k == 1) begin
               check("addr_hsel", 32'(mHSEL), 32'h1);
               check("addr_hsize", 32'(mHSIZE), 32'(exp_hsize));
               check("addr_hwrite", 32'(mHWRITE), 32'(we));
               check("addr_hburst", 32'(mHBURST), 32'h0);
            end
         end
         @(negedge clk);
         check("data_htrans", 32'(mHTRANS), 32'h0);
         check("data_hsel", 32'(mHSEL), 32'h0);
         if (we) check("data_hwdata", mHWDATA, dat);
      end else begin
         @(negedge clk);
         check("noxfer_htrans", 32'(mHTRANS), 32'h0);
      end
      n = 0;
      while (!(wb_ack_o || wb_err_o) && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!(wb_ack_o || wb_err_o)) begin
         check("resp_timeout", 32'h0, 32'h1);
         exp_q.delete();
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(negedge clk);
      check("pulse_end", 32'({wb_ack_o, wb_err_o}), 32'h0);
      if (xfer && we && !err_resp) check("slave_wdata", cap_wdata, dat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      rst_n_i = 1'b0;
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
      wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_htrans", 32'(mHTRANS), 32'h0);
      check("rst_hsel", 32'(mHSEL), 32'h0);
      check("rst_hsize", 32'(mHSIZE), 32'h2);
      check("rst_hprot", 32'(mHPROT), 32'h3);
      check("rst_hburst", 32'(mHBURST), 32'h0);
      check("rst_haddr", mHADDR, 32'h0);
      check("rst_pulses", 32'({wb_ack_o, wb_err_o}), 32'h0);
      check("rst_hready", 32'(mHREADY), 32'h1);
      rst_n_i = 1'b1;
      repeat (2) @(negedge clk);

      // Zero-wait write
      beat(32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 4'hF, 0, 0, 1'b0, 32'h0,
           32'h1000_0004, 3'b010, 1'b1);
      // Read with two data-phase waits
      beat(32'h2000_0000, 32'h0, 1'b0, 4'hF, 0, 2, 1'b0, 32'h1234_5678,
           32'h2000_0000, 3'b010, 1'b1);
      // Read with three address-phase waits
      beat(32'h2000_0010, 32'h0, 1'b0, 4'hF, 3, 0, 1'b0, 32'hCAFE_F00D,
           32'h2000_0010, 3'b010, 1'b1);
      // Two-cycle ERROR on a write, then a normal read
      beat(32'h4000_0000, 32'h1111_2222, 1'b1, 4'hF, 0, 0, 1'b1, 32'h0,
           32'h4000_0000, 3'b010, 1'b1);
      beat(32'h4000_0004, 32'h0, 1'b0, 4'hF, 1, 1, 1'b0, 32'h0BAD_C0DE,
           32'h4000_0004, 3'b010, 1'b1);

`ifdef WB_AHB_SIZE_DECODE_EN
      beat(32'h3000_0000, 32'h00AB_0000, 1'b1, 4'b0100, 0, 0, 1'b0, 32'h0,
           32'h3000_0002, 3'b000, 1'b1);
      beat(32'h3000_0000, 32'hABCD_0000, 1'b1, 4'b1100, 0, 0, 1'b0, 32'h0,
           32'h3000_0002, 3'b001, 1'b1);
      beat(32'h3000_0000, 32'h0, 1'b1, 4'b0101, 0, 0, 1'b0, 32'h0,
           32'h0, 3'b000, 1'b0);
      beat(32'h3000_0000, 32'h0, 1'b1, 4'b0000, 0, 0, 1'b0, 32'h0,
           32'h0, 3'b000, 1'b0);
`else
      // Lanes ignored: word transfer, low address bits cleared
      beat(32'h5000_0007, 32'h5A5A_A5A5, 1'b1, 4'b0101, 0, 0, 1'b0, 32'h0,
           32'h5000_0004, 3'b010, 1'b1);
`endif

      // Cycle dropped during the data phase of a read
      p0 = pulse_cnt;
      cfg_aw = 0; cfg_dw = 0; cfg_err = 1'b0; cfg_rdata = 32'hAAAA_5555;
      @(negedge clk);
      wb_adr_i = 32'h2000_0020; wb_we_i = 1'b0; wb_sel_i = 4'hF;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      exp_xfer++;
      @(negedge clk);
      @(negedge clk);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (4) @(negedge clk);
      check("drop_no_pulse", 32'(pulse_cnt), 32'(p0));
      check("drop_xfer_done", 32'(n_xfer), 32'(exp_xfer));
      check("drop_dat_held", wb_dat_o, 32'h0BAD_C0DE);
      check("drop_htrans", 32'(mHTRANS), 32'h0);

      // Asynchronous reset in the data phase
      p0 = pulse_cnt;
      cfg_aw = 0; cfg_dw = 4; cfg_err = 1'b0; cfg_rdata = 32'h7777_8888;
      @(negedge clk);
      wb_adr_i = 32'h6000_0008; wb_dat_i = 32'h9999_0000; wb_we_i = 1'b1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      exp_xfer++;
      repeat (3) @(negedge clk);
      #2 rst_n_i = 1'b0;
      #1;
      check("arst_htrans", 32'(mHTRANS), 32'h0);
      check("arst_hsel", 32'(mHSEL), 32'h0);
      check("arst_haddr", mHADDR, 32'h0);
      check("arst_hwdata", mHWDATA, 32'h0);
      check("arst_hwrite", 32'(mHWRITE), 32'h0);
      check("arst_hsize", 32'(mHSIZE), 32'h2);
      check("arst_wbdat", wb_dat_o, 32'h0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n_i = 1'b1;
      repeat (3) @(negedge clk);
      check("arst_no_pulse", 32'(pulse_cnt), 32'(p0));

      // Normal beat after reset
      beat(32'h6000_0000, 32'h0, 1'b0, 4'hF, 0, 0, 1'b0, 32'h600D_F00D,
           32'h6000_0000, 3'b010, 1'b1);

      repeat (3) @(negedge clk);
      check("total_xfers", 32'(n_xfer), 32'(exp_xfer));
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_ahb3lite_master_bridge.md
# wb_ahb3lite_master_bridge

Wishbone-classic slave to AHB3-Lite master bridge sitting directly downstream of each DMA engine master port (wb0/wb1 master side). Each Wishbone beat issued by the DMA becomes one AHB3-Lite SINGLE/NONSEQ transfer on the system bus. Read data, completion and bus errors are returned as `wb_dat_o`, `wb_ack_o` and `wb_err_o`.

## Interface
- `HPROT_VAL`, default 4'b0011: constant driven on `mHPROT` (data, privileged).
- `clk_i`  in  1  system clock, rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `wb_adr_i`  in  32  byte address from DMA master.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, valid while `wb_ack_o`=1.
- `wb_sel_i`  in  4  byte lanes.
- `wb_we_i`  in  1  1=write.
- `wb_cyc_i`, `wb_stb_i`  in  1 each  cycle / strobe.
- `wb_ack_o`, `wb_err_o`  out  1 each  one-cycle completion / error pulses.
- `mHSEL`  out  1;  `mHADDR`  out  32;  `mHWDATA`  out  32;  `mHWRITE`  out  1.
- `mHSIZE`  out  3;  `mHBURST`  out  3 (always 3'b000);  `mHPROT`  out  4;  `mHTRANS`  out  2.
- `mHRDATA`  in  32;  `mHREADYOUT`  in  1 (slave ready);  `mHRESP`  in  1 (1=ERROR).
- `mHREADY`  out  1  combinational copy of `mHREADYOUT`.

## Operation
- Reset values: `mHTRANS`=2'b00, `mHSEL`=0, `mHADDR`=0, `mHWDATA`=0, `mHWRITE`=0, `mHSIZE`=3'b010, `mHBURST`=0, `mHPROT`=HPROT_VAL, `wb_dat_o`=0, `wb_ack_o`=0, `wb_err_o`=0; state IDLE.
- FSM IDLE -> ADDR -> DATA -> IDLE.
- IDLE: request = `wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o`. On request, register `mHADDR`, `mHWRITE`, `mHSIZE`, `mHWDATA`<=`wb_dat_i`; set `mHTRANS`=NONSEQ (2'b10), `mHSEL`=1; go ADDR.
- ADDR: address phase on bus. Hold all address signals while `mHREADYOUT`=0. On `mHREADYOUT`=1: `mHTRANS`<=IDLE, `mHSEL`<=0; go DATA.
- DATA: `mHWDATA` held. `mHREADYOUT`=0 & `mHRESP`=0 -> wait. `mHREADYOUT`=0 & `mHRESP`=1 (first error cycle) -> wait. `mHREADYOUT`=1 & `mHRESP`=0 -> `wb_dat_o`<=`mHRDATA` (reads), `wb_ack_o`<=1. `mHREADYOUT`=1 & `mHRESP`=1 -> `wb_err_o`<=1. Either case -> IDLE.
- `wb_ack_o`/`wb_err_o` high exactly one cycle; the request gate blocks reissue of the same beat while the pulse is high.
- `wb_cyc_i` dropped after IDLE exit: AHB transfer completes normally (no abort on AHB), ack/err suppressed, `wb_dat_o` not updated.
- Never two transfers outstanding; `mHBURST`=SINGLE always; `wb_cti_i`/`wb_bte_i` not used.

## Timing
- Zero-wait slave: request sampled cycle 0; NONSEQ on bus cycle 1; data phase cycle 2; `wb_ack_o` high cycle 3; next request accepted cycle 4. Throughput 1 beat / 4 cycles.
- Each slave wait state in ADDR or DATA adds exactly one cycle.
- Error: two-cycle AHB ERROR response -> `wb_err_o` in the cycle after the second error cycle.
- Async reset mid-transfer: all outputs to reset values immediately, FSM IDLE; no ack/err.

## Configuration
- `WB_AHB_SIZE_DECODE_EN` defined: `wb_sel_i` decoded. 4'b1111 -> HSIZE 3'b010, HADDR[1:0]=00. 4'b0011/4'b1100 -> HSIZE 3'b001, HADDR[1:0]=00/10. Single-bit sel -> HSIZE 3'b000, HADDR[1:0]=lane index. Any other pattern, incl. 4'b0000 -> no AHB transfer; `wb_err_o` pulses in the cycle after the request; FSM stays IDLE.
- Not defined: `wb_sel_i` ignored; HSIZE always 3'b010; HADDR[1:0] forced 00.

## Test plan
- Write 0xDEADBEEF to 0x1000_0004, zero-wait slave -> NONSEQ cycle 1, HWDATA 0xDEADBEEF cycle 2, HSIZE 3'b010, `wb_ack_o` cycle 3 only.
- Read 0x2000_0000, slave inserts 2 data-phase waits returning 0x12345678 -> `wb_ack_o` cycle 5, `wb_dat_o`=0x12345678.
- Slave holds `mHREADYOUT`=0 for 3 cycles in address phase -> HADDR/HTRANS stable throughout; ack 3 cycles later than nominal.
- Two-cycle ERROR on write -> `wb_err_o` one pulse, no `wb_ack_o`; next request issued normally.
- `wb_cyc_i` deasserted in cycle 2 of a read -> AHB data phase completes, no ack/err; async reset asserted in DATA -> all outputs to reset values same cycle.
- With `WB_AHB_SIZE_DECODE_EN`: sel 4'b0100 at 0x3000_0000 -> HSIZE 3'b000, HADDR 0x3000_0002; sel 4'b0101 -> `wb_err_o` cycle 1, `mHTRANS` stays IDLE.
